add_stream_stage: RTL

ADD_STREAM_STAGE -- requirements
Module: add_stream_stage

---
 rtl/add_stream_stage.sv | 133 +++++++++++++
 1 files changed

// File: rtl/add_stream_stage.sv
// Two-stage valid/ready add/sub/accumulate stage: S1 holds the operands, a
// chained 4-bit carry-lookahead adder sits between S1 and the S2 result register.
module add_stream_stage #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  input  logic             in_cin,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int unsigned NB = WIDTH / 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_CLR = 2'b11
  } op_e;

  if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_width
    $error("add_stream_stage: WIDTH must be a multiple of 4 in 4..64");
  end

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_cin;
  op_e              s1_op;
  logic [WIDTH-1:0] acc;

  logic             s2_advance;
  logic             s1_move;
  logic             accept;

  logic [WIDTH-1:0] a_eff;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic [NB:0]      blk_c;
  logic             ovf;

  assign s2_advance = !out_valid || out_ready;
  assign s1_move    = s1_valid && s2_advance;
  assign in_ready   = rst_n && (!s1_valid || s2_advance);
  assign accept     = in_valid && in_ready;

  // ACC reads acc at S1; acc is written on the same edge that S1 advances,
  // so a following ACC beat entering S1 sees the freshly written value.
  assign a_eff    = (s1_op == OP_ACC) ? acc : s1_a;
  assign b_eff    = (s1_op == OP_SUB) ? ~s1_b : s1_b;
  assign blk_c[0] = (s1_op == OP_SUB) ? 1'b1 : s1_cin;

  for (genvar k = 0; k < NB; k++) begin : g_cla
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a_eff[4*k +: 4] & b_eff[4*k +: 4];
    assign p = a_eff[4*k +: 4] ^ b_eff[4*k +: 4];

    assign c[0] = blk_c[k];
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign blk_c[k+1] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                      | (p[3] & p[2] & p[1] & g[0])
                      | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign sum[4*k +: 4] = p ^ c;
  end

  assign ovf = (a_eff[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_eff[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_cin    <= 1'b0;
      s1_op     <= OP_ADD;
      acc       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
    end else begin
      if (s2_advance) begin
        out_valid <= s1_valid;
      end

      if (s1_move) begin
        if (s1_op == OP_CLR) begin
          out_sum  <= '0;
          out_cout <= 1'b0;
          out_ovf  <= 1'b0;
          out_zero <= 1'b1;
          acc      <= '0;
        end else begin
          out_sum  <= sum;
          out_cout <= blk_c[NB];
          out_ovf  <= ovf;
          out_zero <= (sum == '0);
          if (s1_op == OP_ACC) begin
            acc <= sum;
          end
        end
      end

      if (accept) begin
        s1_valid <= 1'b1;
        s1_a     <= in_A;
        s1_b     <= in_B;
        s1_cin   <= in_cin;
        s1_op    <= op_e'(in_op);
      end else if (s1_move) begin
        s1_valid <= 1'b0;
      end
    end
  end

endmodule
